rst_sync: RTL and testbench



---
 rtl/rst_sync_pkg.sv | 17 +
 rtl/rst_sync_ff.sv | 22 ++
 rtl/rst_sync.sv | 78 +++++++
 tb/tb_rst_sync.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_sync_pkg.sv
// Shared constants for the reset synchronizer: stage-count limits and
// reset polarity.
package rst_sync_pkg;

    localparam int RST_SYNC_STAGES_DEFAULT = 2;
    localparam int RST_SYNC_STAGES_MIN     = 2;
    localparam int RST_SYNC_STAGES_MAX     = 8;

    localparam logic RST_ACTIVE   = 1'b0;
    localparam logic RST_INACTIVE = 1'b1;

    // True when a stage count is usable for metastability filtering.
    function automatic bit stages_legal(input int n);
        return (n >= RST_SYNC_STAGES_MIN) && (n <= RST_SYNC_STAGES_MAX);
    endfunction

endpackage

// File: rtl/rst_sync_ff.sv
// Single synchronizer cell: a D flop with an asynchronous active-low clear.
// Kept as its own module so timing constraints can find every cell by name
// (false path on the clear pin, max-delay between cells).
module rst_sync_ff
    import rst_sync_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    // Clear immediately on reset, otherwise sample D on the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_ACTIVE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts Sync_RST asynchronously with RST and
// releases it synchronously to CLK after NUM_STAGES rising edges.
// Optional macro RST_SYNC_ASSERT_EN compiles in simulation-only checks;
// it adds no logic to the chain itself.
module rst_sync
    import rst_sync_pkg::*;
#(
    parameter int NUM_STAGES = RST_SYNC_STAGES_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    output logic Sync_RST
);

    logic [NUM_STAGES-1:0] stage_q;
    logic [NUM_STAGES-1:0] stage_d;

    if (!stages_legal(NUM_STAGES)) begin : g_bad_stages
        $error("rst_sync: NUM_STAGES=%0d is outside %0d..%0d",
               NUM_STAGES, RST_SYNC_STAGES_MIN, RST_SYNC_STAGES_MAX);
    end

    // The head of the chain loads the released level; each later cell
    // takes its neighbour's output, so a 1 walks one cell per edge.
    assign stage_d = {stage_q[NUM_STAGES-2:0], RST_INACTIVE};

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        rst_sync_ff u_ff (
            .clk   (CLK),
            .rst_n (RST),
            .d     (stage_d[i]),
            .q     (stage_q[i])
        );
    end

    // Output comes straight from the last flop; no gating after it.
    assign Sync_RST = stage_q[NUM_STAGES-1];

`ifdef RST_SYNC_ASSERT_EN
    int   chk_known_edges;
    int   chk_high_edges;
    logic chk_prev_sync;

    // Track edges seen with RST known (arms the X check once the chain has
    // been flushed or cleared) and edges seen with RST released.
    always @(posedge CLK or negedge RST) begin
        if (RST === 1'b0) begin
            chk_high_edges  <= 0;
            chk_known_edges <= NUM_STAGES;
        end else begin
            if (!$isunknown(RST) && chk_known_edges < NUM_STAGES)
                chk_known_edges <= chk_known_edges + 1;
            if (RST === 1'b1 && chk_high_edges < 255)
                chk_high_edges <= chk_high_edges + 1;
        end
    end

    // Inspect the output on the falling edge, well away from its update.
    always @(negedge CLK) begin
        if (RST === 1'b0 && Sync_RST !== 1'b0)
            $error("[%0t] rst_sync: Sync_RST released while RST asserted", $time);
        if (chk_known_edges >= NUM_STAGES && $isunknown(Sync_RST))
            $error("[%0t] rst_sync: Sync_RST unknown", $time);
        if (chk_prev_sync !== 1'b1 && Sync_RST === 1'b1 &&
            chk_high_edges < NUM_STAGES - 1)
            $error("[%0t] rst_sync: Sync_RST released after only %0d edges",
                   $time, chk_high_edges);
        chk_prev_sync <= Sync_RST;
    end

    // A release must line up with a rising clock edge.
    always @(posedge Sync_RST) begin
        if (CLK !== 1'b1)
            $error("[%0t] rst_sync: Sync_RST rose away from a CLK edge", $time);
    end
`endif

endmodule

// File: tb/tb_rst_sync.sv
// Bench for rst_sync: two instances (2 and 4 stages) share clock and reset
// and are compared against an edge-counting reference model.
module tb_rst_sync;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       clk_run   = 1'b1;
    logic       jitter_en = 1'b0;
    logic [1:0] sync_v;

    int tests   = 0;
    int failed  = 0;
    int half_hi = 5;
    int half_lo = 5;
    int rise_edges = 0;
    int stages [2] = '{2, 4};

    rst_sync #(.NUM_STAGES(2)) dut2 (.CLK(clk), .RST(rst), .Sync_RST(sync_v[0]));
    rst_sync #(.NUM_STAGES(4)) dut4 (.CLK(clk), .RST(rst), .Sync_RST(sync_v[1]));

    // Stoppable clock with optional random jitter on each half period.
    always begin
        if (clk_run) begin
            half_hi = jitter_en ? 4 + int'($urandom_range(0, 3)) : 5;
            half_lo = jitter_en ? 4 + int'($urandom_range(0, 3)) : 5;
            #(half_hi) clk = 1'b1;
            #(half_lo) clk = 1'b0;
        end else begin
            #1;
        end
    end

    // Reference model: number of rising edges seen since the last release.
    always @(posedge clk or negedge rst) begin
        if (rst !== 1'b1) rise_edges = 0;
        else if (rise_edges < 1000) rise_edges = rise_edges + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog");
    end

    task automatic mid_period();
        @(negedge clk);
        #(1 + $urandom_range(0, 1));
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic exp;
        repeat (10) edge_sample();
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (sync_v[d] !== 1'b1) begin
                failed++;
                $display("FAIL powerup n=%0d got=%b exp=1", stages[d], sync_v[d]);
            end
        end
        mid_period();
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (sync_v[d] !== 1'b0) begin
                failed++;
                $display("FAIL assert_immediate n=%0d got=%b exp=0", stages[d], sync_v[d]);
            end
        end
        mid_period();
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (sync_v[d] !== 1'b0) begin
                failed++;
                $display("FAIL pulse_end n=%0d got=%b exp=0", stages[d], sync_v[d]);
            end
        end
        rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            edge_sample();
            for (int d = 0; d < 2; d++) begin
                exp = (rst === 1'b1) && (rise_edges >= stages[d]);
                tests++;
                if (sync_v[d] !== exp) begin
                    failed++;
                    $display("FAIL release_edge n=%0d edge=%0d got=%b exp=%b",
                             stages[d], k, sync_v[d], exp);
                end
            end
        end
        repeat (3) edge_sample();
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (sync_v[d] !== 1'b1) begin
                failed++;
                $display("FAIL release_hold n=%0d got=%b exp=1", stages[d], sync_v[d]);
            end
        end
    endtask

    task automatic test_edge_release();
        mid_period();
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (sync_v[d] !== 1'b0) begin
                failed++;
                $display("FAIL edge_pulse n=%0d got=%b exp=0", stages[d], sync_v[d]);
            end
        end
        @(posedge clk);
        rst = 1'b1;
        // The coincident edge may or may not count: only the firm bounds apply.
        for (int k = 1; k <= 5; k++) begin
            edge_sample();
            for (int d = 0; d < 2; d++) begin
                if (k < stages[d] - 1) begin
                    tests++;
                    if (sync_v[d] !== 1'b0) begin
                        failed++;
                        $display("FAIL edge_early n=%0d edge=%0d got=%b exp=0",
                                 stages[d], k, sync_v[d]);
                    end
                end else if (k >= stages[d] + 1) begin
                    tests++;
                    if (sync_v[d] !== 1'b1) begin
                        failed++;
                        $display("FAIL edge_late n=%0d edge=%0d got=%b exp=1",
                                 stages[d], k, sync_v[d]);
                    end
                end
            end
        end
        repeat (3) edge_sample();
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (sync_v[d] !== 1'b1) begin
                failed++;
                $display("FAIL edge_hold n=%0d got=%b exp=1", stages[d], sync_v[d]);
            end
        end
    endtask

    task automatic test_reassert();
        logic exp;
        int   hold;
        for (int it = 0; it < 13; it++) begin
            mid_period();
            rst = 1'b0;
            #1;
            repeat ($urandom_range(1, 3)) begin
                edge_sample();
                for (int d = 0; d < 2; d++) begin
                    tests++;
                    if (sync_v[d] !== 1'b0) begin
                        failed++;
                        $display("FAIL reassert_low n=%0d iter=%0d got=%b exp=0",
                                 stages[d], it, sync_v[d]);
                    end
                end
            end
            mid_period();
            rst = 1'b1;
            // First pass is the fixed one-edge re-assert; the last pass is the final release.
            hold = (it == 0) ? 1 : (it == 12) ? 6 : int'($urandom_range(0, 5));
            for (int k = 0; k < hold; k++) begin
                edge_sample();
                for (int d = 0; d < 2; d++) begin
                    exp = (rst === 1'b1) && (rise_edges >= stages[d]);
                    tests++;
                    if (sync_v[d] !== exp) begin
                        failed++;
                        $display("FAIL reassert_rel n=%0d iter=%0d edge=%0d got=%b exp=%b",
                                 stages[d], it, k + 1, sync_v[d], exp);
                    end
                end
            end
        end
    endtask

    task automatic test_clock_stopped();
        logic exp;
        repeat (6) edge_sample();
        @(negedge clk);
        clk_run = 1'b0;
        #30;
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (sync_v[d] !== 1'b0) begin
                failed++;
                $display("FAIL stopped_assert n=%0d got=%b exp=0", stages[d], sync_v[d]);
            end
        end
        #40;
        rst = 1'b1;
        #40;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (sync_v[d] !== 1'b0) begin
                failed++;
                $display("FAIL stopped_release n=%0d got=%b exp=0", stages[d], sync_v[d]);
            end
        end
        clk_run = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            edge_sample();
            for (int d = 0; d < 2; d++) begin
                exp = (rst === 1'b1) && (rise_edges >= stages[d]);
                tests++;
                if (sync_v[d] !== exp) begin
                    failed++;
                    $display("FAIL restart_edge n=%0d edge=%0d got=%b exp=%b",
                             stages[d], k, sync_v[d], exp);
                end
            end
        end
    endtask

    task automatic test_long_run();
        jitter_en = 1'b1;
        for (int k = 0; k < 300; k++) begin
            edge_sample();
            for (int d = 0; d < 2; d++) begin
                tests++;
                if (sync_v[d] !== 1'b1) begin
                    failed++;
                    $display("FAIL long_run n=%0d edge=%0d got=%b exp=1",
                             stages[d], k, sync_v[d]);
                end
            end
        end
        jitter_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_edge_release();
        test_reassert();
        test_clock_stopped();
        test_long_run();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
